// File: rtl/gpio_in_filter_pkg.sv
// Shared defaults and sizing helpers for the GPIO input conditioning stage.
package gpio_in_pkg;

  localparam int GPIO_WIDTH        = 32;
  localparam int GPIO_TICK_DIV     = 1200;
  localparam int GPIO_STABLE_TICKS = 10;

  function automatic int cnt_w(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/gpio_in_filter_if.sv
// Bundle of pad-side inputs and filtered outputs between the pads and the core.
interface gpio_in_filter_if
  import gpio_in_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
);

  logic [WIDTH-1:0] pad_i;
  logic [WIDTH-1:0] db_en_i;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             any_edge_o;

  modport slave (
    input  pad_i,
    input  db_en_i,
    output gpio_o,
    output rise_o,
    output fall_o,
    output any_edge_o
  );

  modport master (
    output pad_i,
    output db_en_i,
    input  gpio_o,
    input  rise_o,
    input  fall_o,
    input  any_edge_o
  );

endinterface

// File: rtl/gpio_in_filter_db_bit.sv
// One GPIO bit: two-flop synchroniser, tick-based debounce counter, stable
// level register and registered rise/fall pulses.
module gpio_db_bit
  import gpio_in_pkg::*;
#(
  parameter int STABLE_TICKS = GPIO_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pad,
  input  logic db_en,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(STABLE_TICKS);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronised level matches the accepted level restarts
  // the count, so only an uninterrupted mismatch can reach acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= pad;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (!db_en) begin
        cnt <= '0;
        if (s2 != level) begin
          level <= s2;
          rise  <= s2;
          fall  <= ~s2;
        end
      end else if (s2 == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(STABLE_TICKS - 1)) begin
          cnt   <= '0;
          level <= s2;
          rise  <= s2;
          fall  <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input filter top: shared debounce prescaler, per-bit filters and the
// combined edge indication for the interrupt logic.
module gpio_in_filter
  import gpio_in_pkg::*;
#(
  parameter int WIDTH        = GPIO_WIDTH,
  parameter int TICK_DIV     = GPIO_TICK_DIV,
  parameter int STABLE_TICKS = GPIO_STABLE_TICKS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  gpio_in_filter_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]    count;
  logic             tick;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // tick is registered one count early so it is high while count sits at TICK_DIV-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (count == PW'(TICK_DIV - 1)) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      tick <= (count == PW'(TICK_DIV - 2));
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_db_bit #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clk   (clk_i),
      .rst   (rst_i),
      .tick  (tick),
      .pad   (bus.pad_i[i]),
      .db_en (bus.db_en_i[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign bus.gpio_o     = level;
  assign bus.rise_o     = rise;
  assign bus.fall_o     = fall;
  assign bus.any_edge_o = |(rise | fall);

endmodule

// File: tb/tb_gpio_in_filter.sv
// Scoreboard bench for gpio_in_filter: stimulus pushes expected level changes,
// a monitor pops and compares them whenever the outputs change or pulse.
module tb_gpio_in_filter;

  localparam int WIDTH        = 32;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int WIN_LO       = 2 + (STABLE_TICKS - 1) * TICK_DIV;
  localparam int WIN_HI       = 1 + STABLE_TICKS * TICK_DIV;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] level;
    logic [31:0] rise;
    logic [31:0] fall;
    int          lo;
    int          hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic rstSeen = 1'b0;

  exp_t        q[$];
  logic [31:0] expLevel = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          levelReq = 0;
  int          doneReq = 0;
  int          lastK = 0;

  gpio_in_filter_if #(.WIDTH(WIDTH)) bus ();

  gpio_in_filter #(
    .WIDTH        (WIDTH),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rstSeen <= rst;
  end

  task automatic applyStimulus(input logic [31:0] pad, input logic [31:0] db);
    bus.pad_i   = pad;
    bus.db_en_i = db;
    lastK       = cyc + 1;
  endtask

  task automatic expectLevel(input logic [31:0] level, input int lo, input int hi);
    exp_t e;
    e.level  = level;
    e.rise   = level & ~expLevel;
    e.fall   = ~level & expLevel;
    e.lo     = lo;
    e.hi     = hi;
    expLevel = level;
    q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: sole owner of the counters.
  initial begin : monitor
    logic [31:0] prevGpio;
    int          levelDone;
    int          finalDone;
    exp_t        e;
    prevGpio  = '0;
    levelDone = 0;
    finalDone = 0;
    forever begin
      @(negedge clk);
      if (rstSeen) begin
        checkOutput("reset_gpio", bus.gpio_o, 32'h0);
        checkOutput("reset_rise", bus.rise_o, 32'h0);
        checkOutput("reset_fall", bus.fall_o, 32'h0);
        checkOutput("reset_any_edge", {31'b0, bus.any_edge_o}, 32'h0);
      end
      if (bus.any_edge_o === 1'b1 || bus.gpio_o !== prevGpio) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_event at cycle %0d: gpio=%h rise=%h fall=%h, required no event",
                   cyc, bus.gpio_o, bus.rise_o, bus.fall_o);
        end else begin
          e = q.pop_front();
          checkOutput("event_gpio", bus.gpio_o, e.level);
          checkOutput("event_rise", bus.rise_o, e.rise);
          checkOutput("event_fall", bus.fall_o, e.fall);
          checkOutput("event_any_edge", {31'b0, bus.any_edge_o},
                      {31'b0, ((e.rise | e.fall) != 32'h0)});
          vectors++;
          if (cyc < e.lo || cyc > e.hi) begin
            miscompares++;
            $display("[TB] FAIL event_cycle: actual=%0d required=%0d..%0d", cyc, e.lo, e.hi);
          end
        end
      end
      prevGpio = bus.gpio_o;
      if (levelReq != levelDone) begin
        levelDone = levelReq;
        checkOutput("held_level", bus.gpio_o, expLevel);
      end
      if (doneReq != 0 && finalDone == 0) begin
        finalDone = 1;
        vectors++;
        if (q.size() != 0) begin
          miscompares++;
          $display("[TB] FAIL missing_events: actual=%0d outstanding required=0", q.size());
        end
      end
    end
  end

  initial begin : stimulus
    int k;
    applyStimulus(ALL, 32'hFFFF_0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Release reset: bypass half rises at k+2, debounced half inside the window.
    rst = 1'b0;
    k = cyc + 1;
    expectLevel(32'h0000_FFFF, k + 2, k + 2);
    expectLevel(ALL, k + WIN_LO, k + WIN_HI);
    repeat (20) @(negedge clk);

    // Everything to bypass and low: all bits fall together.
    applyStimulus(32'h0, 32'h0);
    expectLevel(32'h0, lastK + 2, lastK + 2);
    repeat (4) @(negedge clk);

    // Bypass toggle of bit 5.
    applyStimulus(32'h20, 32'h0);
    expectLevel(32'h20, lastK + 2, lastK + 2);
    repeat (3) @(negedge clk);
    applyStimulus(32'h0, 32'h0);
    expectLevel(32'h0, lastK + 2, lastK + 2);
    repeat (4) @(negedge clk);

    // Debounce accept on bit 0.
    applyStimulus(32'h0, ALL);
    repeat (6) @(negedge clk);
    applyStimulus(32'h1, ALL);
    expectLevel(32'h1, lastK + WIN_LO, lastK + WIN_HI);
    repeat (20) @(negedge clk);

    // Glitch rejection on bit 3: one short pulse, then bursts with 1-cycle gaps.
    applyStimulus(32'h9, ALL);
    repeat (5) @(negedge clk);
    applyStimulus(32'h1, ALL);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h9, ALL);
      repeat (5) @(negedge clk);
      applyStimulus(32'h1, ALL);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    levelReq++;
    repeat (2) @(negedge clk);

    // Simultaneous rise on bits 31:30.
    applyStimulus(32'hC000_0001, ALL);
    expectLevel(32'hC000_0001, lastK + WIN_LO, lastK + WIN_HI);
    repeat (20) @(negedge clk);

    applyStimulus(32'h0, 32'h0);
    expectLevel(32'h0, lastK + 2, lastK + 2);
    repeat (4) @(negedge clk);
    applyStimulus(32'h0, ALL);
    repeat (4) @(negedge clk);

    // Reset 6 cycles into a debounce of bit 7: a fresh window follows.
    applyStimulus(32'h80, ALL);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    k = cyc + 1;
    expectLevel(32'h80, k + WIN_LO, k + WIN_HI);
    repeat (20) @(negedge clk);

    // Bit 30 switched to bypass mid-count updates one edge later.
    applyStimulus(32'h4000_0080, ALL);
    repeat (4) @(negedge clk);
    applyStimulus(32'h4000_0080, 32'hBFFF_FFFF);
    expectLevel(32'h4000_0080, lastK, lastK);
    repeat (10) @(negedge clk);

    doneReq = 1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Input-conditioning stage between the GPIO pads and the SoC core's `gpio_i` bus. It synchronises each asynchronous pad input into `clk_i` with two flops. Each bit can then be debounced or bypassed, and the block emits single-cycle rise/fall pulses for the core's GPIO interrupt logic. It replaces the direct `gpio_i = gpio` pad feed-through at the FPGA top level.

## Interface
- `WIDTH`, 32: number of GPIO bits.
- `TICK_DIV`, 1200: prescaler period in clock cycles (100 µs at 12 MHz); must be ≥ 2.
- `STABLE_TICKS`, 10: number of consecutive tick strobes a new level must persist before it is accepted; must be ≥ 1.
- `clk_i`  in  1: single clock, same domain as the SoC core (PLL 12 MHz output).
- `rst_i`  in  1: reset, synchronous, active-high.
- `pad_i`  in  WIDTH: raw pad levels, asynchronous to `clk_i`.
- `db_en_i`  in  WIDTH: per-bit debounce enable; 0 selects bypass (synchronised level passed straight through).
- `gpio_o`  out  WIDTH: filtered level, registered; feeds the core's `gpio_i`.
- `rise_o`  out  WIDTH: one-cycle pulse when `gpio_o[i]` goes 0→1, registered.
- `fall_o`  out  WIDTH: one-cycle pulse when `gpio_o[i]` goes 1→0, registered.
- `any_edge_o`  out  1: OR-reduction of `rise_o | fall_o`; combinational from registers.

## Operation
- **Synchroniser:** per bit, `s1 <= pad_i`, then `s2 <= s1`. Only `s2` is used downstream.
- **Prescaler:** a shared counter counts 0..TICK_DIV-1 and wraps. Registered `tick` is high for exactly one cycle per wrap, at count TICK_DIV-1.
- **Per-bit counter** `cnt`, width `$clog2(STABLE_TICKS+1)`. Evaluated at each clock edge in this priority order:
  - `db_en_i[i]==0` (bypass): `gpio_o[i] <= s2[i]` and `cnt <= 0`.
  - `s2[i]==gpio_o[i]`: `cnt <= 0`. Any mismatch interruption restarts the count.
  - Mismatch with `tick` high:
    - if `cnt==STABLE_TICKS-1`, then `gpio_o[i] <= s2[i]` and `cnt <= 0`;
    - otherwise `cnt <= cnt+1`.
  - Mismatch with `tick` low: hold.
- **Edge pulses:** `rise_o[i]`/`fall_o[i]` are registered in the same edge that updates `gpio_o[i]`. A pulse is therefore visible in the same cycle as the new level, and deasserts the following cycle. Rise and fall on one bit are never both asserted.
- **Debounce-enable changes:**
  - Changing `db_en_i[i]` takes effect on the next edge.
  - Switching to bypass discards any partial count.
  - Switching to debounce starts from `cnt=0`.
- **Independence:** bits are independent. Simultaneous edges on several bits produce simultaneous pulses.
- **Saturation:** `cnt` never exceeds STABLE_TICKS-1, so no wrap-around is possible.

## Timing
- **Reset:** `rst_i` high at an edge clears `s1`, `s2`, `gpio_o`, `rise_o`, `fall_o`, all counters, the prescaler and `tick`, so `any_edge_o` reads 0. Reset mid-count discards all progress, and the first pulses after reset reflect changes from 0.
- Let `k` be the edge at which `s1` captures a pad change.
  - `s2` changes at `k+1`.
  - **Bypass:** `gpio_o` changes at `k+2`.
  - **Debounce:** `gpio_o` changes at the edge that samples the STABLE_TICKS-th `tick` seen with a continuous mismatch. That is `k+2+(STABLE_TICKS-1)*TICK_DIV` to `k+1+STABLE_TICKS*TICK_DIV` inclusive.
- **Throughput:** one level change per bit per accepted debounce window.
- **Input pulse width:** pad pulses shorter than `(STABLE_TICKS-1)*TICK_DIV+1` cycles are always rejected.

## Structure
- **Package `gpio_in_pkg`:** holds the default constants `GPIO_WIDTH=32`, `GPIO_TICK_DIV=1200` and `GPIO_STABLE_TICKS=10`, and a `cnt_w` function computing `$clog2(STABLE_TICKS+1)`.
- **Sub-module `gpio_db_bit`:** one instance per bit via generate. It contains the two-flop sync, counter, stable level and edge pulses.
- **Top level:** holds the prescaler/`tick` and the `any_edge_o` reduction.

## Test plan
All scenarios use `TICK_DIV=4`, `STABLE_TICKS=3`, `WIDTH=32`.
1. **Reset:** hold `rst_i` for 2 cycles with `pad_i=32'hFFFF_FFFF`, then release → all outputs 0 during reset. Bypass bits rise at `k+2` with `rise_o` = bypass mask for exactly 1 cycle.
2. **Bypass:** `db_en_i=0`, toggle `pad_i[5]` 0→1→0 with 3-cycle spacing → `gpio_o[5]` follows at `k+2`. `rise_o[5]`, then `fall_o[5]`, one cycle each; `any_edge_o` is high in those cycles.
3. **Debounce accept:** `db_en_i=32'hFFFF_FFFF`, set `pad_i[0]` 0→1 and hold for 20 cycles → `gpio_o[0]` rises at an edge in `k+10..k+13` with a single `rise_o[0]` pulse, and no other bit changes.
4. **Glitch reject:** `pad_i[3]` high for 5 cycles, then low → `gpio_o[3]` stays 0 and no pulses occur. Repeat with 5-cycle bursts separated by 1 low cycle → still no change.
5. **Simultaneous and mid-operation:**
   - Raise `pad_i[31:30]` together → both `rise_o` bits pulse in the same cycle.
   - Assert `rst_i` for 1 cycle 6 cycles into a debounce → no pulse, and a fresh full window is required afterwards.
   - Clear `db_en_i[30]` mid-count → `gpio_o[30]` updates 1 edge later.
